// File: rtl/instr_fetch.sv
// Instruction fetch: issues program-memory reads and buffers decoded words in a 2-entry queue.
// Latency: memory data captured 1 cycle after issue; first out_valid 3 cycles after reset release.
// Backpressure: out_ready=0 holds the head stable; issue stops when queue plus in-flight read would exceed 2.
module instr_fetch #(
  parameter  int OPCODE_WIDTH = 5,
  parameter  int MEM_WIDTH    = 5,
  parameter  int PC_WIDTH     = 8,
  localparam int INSTR_WIDTH  = OPCODE_WIDTH + 3*(2+MEM_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_en,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0]  imem_data,
  input  logic                    jump_en,
  input  logic [PC_WIDTH-1:0]     jump_addr,
  input  logic                    halt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPCODE_WIDTH-1:0] op_code,
  output logic [1:0]              dest_choice,
  output logic [MEM_WIDTH-1:0]    dest_addr,
  output logic [1:0]              source1_choice,
  output logic [MEM_WIDTH-1:0]    source1_addr,
  output logic [1:0]              source2_choice,
  output logic [MEM_WIDTH-1:0]    source2_addr,
  output logic [PC_WIDTH-1:0]     pc_out
);

  localparam int ENTRY_W = INSTR_WIDTH + PC_WIDTH;

  // Field positions inside the instruction word (LSB side first)
  localparam int S2A_LSB = 0;
  localparam int S2C_LSB = MEM_WIDTH;
  localparam int S1A_LSB = MEM_WIDTH + 2;
  localparam int S1C_LSB = 2*MEM_WIDTH + 2;
  localparam int DA_LSB  = 2*MEM_WIDTH + 4;
  localparam int DC_LSB  = 3*MEM_WIDTH + 4;
  localparam int OP_LSB  = 3*MEM_WIDTH + 6;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  logic [ENTRY_W-1:0]  fifo_mem [2];
  logic                head;
  logic [1:0]          count;

  logic                transfer;
  logic                room;
  logic                issue;
  logic                capture;
  logic                tail;
  logic [ENTRY_W-1:0]  head_entry;
  logic [INSTR_WIDTH-1:0] head_instr;

  assign out_valid = (count != 2'd0);
  assign transfer  = out_valid & out_ready;

  // Room exists when buffered + in-flight words, less the one leaving now, stays below 2.
  assign room = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, transfer});

  // Halt gates issue directly so no read goes out on the cycle halt is first raised.
  assign issue     = (state == RUN) & ~halt & ~jump_en & room;
  assign imem_en   = issue;
  assign imem_addr = pc;

  // A redirect throws away the response of the read issued before it.
  assign capture = inflight & ~jump_en;

  // With count in {0,1} at capture time, the free slot is head offset by count.
  assign tail = head ^ count[0];

  // Control FSM: one idle cycle out of reset, then run/halt by the halt level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (halt)  state <= HALTED;
        HALTED:  if (!halt) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // Program counter and the single outstanding-read tracker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (jump_en) begin
      pc       <= jump_addr;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        inflight_pc <= pc;
      end
    end
  end

  // Two-entry queue of {instruction, pc}; flushed on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else if (jump_en) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (capture) fifo_mem[tail] <= {imem_data, inflight_pc};
      if (transfer) head <= ~head;
      count <= count + {1'b0, capture} - {1'b0, transfer};
    end
  end

  // Head entry drives the decoded outputs; everything reads zero while empty.
  always_comb begin
    head_entry = '0;
    if (out_valid) head_entry = fifo_mem[head];
  end

  assign head_instr     = head_entry[ENTRY_W-1:PC_WIDTH];
  assign pc_out         = head_entry[PC_WIDTH-1:0];
  assign op_code        = head_instr[OP_LSB +: OPCODE_WIDTH];
  assign dest_choice    = head_instr[DC_LSB +: 2];
  assign dest_addr      = head_instr[DA_LSB +: MEM_WIDTH];
  assign source1_choice = head_instr[S1C_LSB +: 2];
  assign source1_addr   = head_instr[S1A_LSB +: MEM_WIDTH];
  assign source2_choice = head_instr[S2C_LSB +: 2];
  assign source2_addr   = head_instr[S2A_LSB +: MEM_WIDTH];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle table, reset corner cases, then random traffic.
// Memory returns a hash of the address so decoded fields identify the fetched pc.
// Random phase compares against a queue-based model of issued/delivered instructions.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [25:0] imem_data = '0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  op_code;
  logic [1:0]  dest_choice, source1_choice, source2_choice;
  logic [4:0]  dest_addr, source1_addr, source2_addr;
  logic [7:0]  pc_out;
  logic [25:0] fields;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_code(op_code),
    .dest_choice(dest_choice), .dest_addr(dest_addr),
    .source1_choice(source1_choice), .source1_addr(source1_addr),
    .source2_choice(source2_choice), .source2_addr(source2_addr),
    .pc_out(pc_out)
  );

  // Instruction word layout MSB..LSB: op, dc, da, s1c, s1a, s2c, s2a
  assign fields = {op_code, dest_choice, dest_addr, source1_choice, source1_addr,
                   source2_choice, source2_addr};

  function automatic logic [25:0] word_of(input logic [7:0] a);
    logic [31:0] t;
    t = {24'd0, a} * 32'd2654435761 + {24'd0, a};
    return t[25:0];
  endfunction

  // Program memory: one-cycle read latency, junk when not strobed.
  always @(posedge clk) begin
    if (imem_en) imem_data <= word_of(imem_addr);
    else         imem_data <= 26'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic       ready;
    logic       hlt;
    logic       jmp;
    logic [7:0] jaddr;
    logic       en;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl[36];

  task automatic setv(input int i, input logic r, input logic h, input logic j, input logic [7:0] ja,
                      input logic e, input logic [7:0] ad, input logic v, input logic [7:0] p);
    tbl[i] = '{ready: r, hlt: h, jmp: j, jaddr: ja, en: e, addr: ad, valid: v, pc: p};
  endtask

  typedef struct {
    logic [7:0] pc;
    bit         cap;
  } ent_t;

  ent_t       q[$];
  logic [7:0] m_pc;
  bit         m_idle, m_halted;
  bit         exp_valid, exp_en, xfer;
  int         occ_after;
  int         halt_left;

  initial begin
    // Reset release, streaming, then 5 cycles of backpressure
    setv(0, 1'b1,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0,8'h00);
    setv(1, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h00, 1'b0,8'h00);
    setv(2, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h01, 1'b0,8'h00);
    for (int i = 3; i < 8; i++) setv(i, 1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1,8'h00);
    setv(8,  1'b1,1'b0,1'b0,8'h00, 1'b1,8'h02, 1'b1,8'h00);
    setv(9,  1'b1,1'b0,1'b0,8'h00, 1'b1,8'h03, 1'b1,8'h01);
    setv(10, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h04, 1'b1,8'h02);
    setv(11, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h05, 1'b1,8'h03);
    // Fill the queue, then redirect to 0x40 while full
    setv(12, 1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1,8'h04);
    setv(13, 1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1,8'h04);
    setv(14, 1'b0,1'b0,1'b1,8'h40, 1'b0,8'h00, 1'b1,8'h04);
    setv(15, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h40, 1'b0,8'h00);
    setv(16, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h41, 1'b0,8'h00);
    setv(17, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h42, 1'b1,8'h40);
    setv(18, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h43, 1'b1,8'h41);
    // Redirect to 0xFE and run across the wrap
    setv(19, 1'b1,1'b0,1'b1,8'hFE, 1'b0,8'h00, 1'b1,8'h42);
    setv(20, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'hFE, 1'b0,8'h00);
    setv(21, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'hFF, 1'b0,8'h00);
    setv(22, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h00, 1'b1,8'hFE);
    setv(23, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h01, 1'b1,8'hFF);
    setv(24, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h02, 1'b1,8'h00);
    setv(25, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h03, 1'b1,8'h01);
    // Halt for 6 cycles: drain buffered and in-flight, then resume at 0x04
    setv(26, 1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b1,8'h02);
    setv(27, 1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b1,8'h03);
    for (int i = 28; i < 32; i++) setv(i, 1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0,8'h00);
    setv(32, 1'b1,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0,8'h00);
    setv(33, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h04, 1'b0,8'h00);
    setv(34, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h05, 1'b0,8'h00);
    setv(35, 1'b1,1'b0,1'b0,8'h00, 1'b1,8'h06, 1'b1,8'h04);

    // Reset state
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_en",    {31'd0, imem_en},   32'd0);
    check("rst_pc",    {24'd0, pc_out},    32'd0);
    check("rst_addr",  {24'd0, imem_addr}, 32'd0);
    check("rst_fields",{6'd0, fields},     32'd0);
    repeat (2) @(negedge clk);

    // Directed table from reset release
    rst = 1'b1;
    for (int i = 0; i < 36; i++) begin
      out_ready = tbl[i].ready;
      halt      = tbl[i].hlt;
      jump_en   = tbl[i].jmp;
      jump_addr = tbl[i].jaddr;
      #1;
      check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].valid});
      check($sformatf("tbl%0d_en", i),    {31'd0, imem_en},   {31'd0, tbl[i].en});
      if (tbl[i].en)
        check($sformatf("tbl%0d_addr", i), {24'd0, imem_addr}, {24'd0, tbl[i].addr});
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d_pc", i),     {24'd0, pc_out}, {24'd0, tbl[i].pc});
        check($sformatf("tbl%0d_fields", i), {6'd0, fields},  {6'd0, word_of(tbl[i].pc)});
      end
      @(negedge clk);
    end

    // Mid-stream reset: outputs clear asynchronously, restart from pc 0
    out_ready = 1'b1; halt = 1'b0; jump_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_valid",  {31'd0, out_valid}, 32'd0);
    check("async_en",     {31'd0, imem_en},   32'd0);
    check("async_pc",     {24'd0, pc_out},    32'd0);
    check("async_fields", {6'd0, fields},     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rel%0d_valid", c), {31'd0, out_valid}, (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("rel%0d_en", c),    {31'd0, imem_en},   (c >= 1) ? 32'd1 : 32'd0);
      if (c >= 1) check($sformatf("rel%0d_addr", c), {24'd0, imem_addr}, 32'(c - 1));
      if (c == 3) begin
        check("rel_pc",     {24'd0, pc_out}, 32'd0);
        check("rel_fields", {6'd0, fields},  {6'd0, word_of(8'h00)});
      end
      @(negedge clk);
    end

    // Random traffic against the queue model
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_pc = 8'h00; m_idle = 1'b1; m_halted = 1'b0; halt_left = 0;
    for (int n = 0; n < 2500; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (halt_left == 0 && $urandom_range(0, 19) == 0) halt_left = $urandom_range(1, 6);
      halt = (halt_left > 0);
      if (halt_left > 0) halt_left--;
      jump_en   = ($urandom_range(0, 24) == 0);
      jump_addr = 8'($urandom);
      #1;
      exp_valid = (q.size() > 0) && q[0].cap;
      xfer      = exp_valid && out_ready;
      occ_after = q.size() - (xfer ? 1 : 0);
      exp_en    = !m_idle && !m_halted && !halt && !jump_en && (occ_after < 2);
      check("rnd_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("rnd_en",    {31'd0, imem_en},   {31'd0, exp_en});
      if (exp_en) check("rnd_addr", {24'd0, imem_addr}, {24'd0, m_pc});
      if (exp_valid) begin
        check("rnd_pc",     {24'd0, pc_out}, {24'd0, q[0].pc});
        check("rnd_fields", {6'd0, fields},  {6'd0, word_of(q[0].pc)});
      end
      if (jump_en) begin
        q.delete();
        m_pc = jump_addr;
      end else begin
        if (xfer) void'(q.pop_front());
        foreach (q[k]) q[k].cap = 1'b1;
        if (exp_en) begin
          q.push_back('{pc: m_pc, cap: 1'b0});
          m_pc = m_pc + 8'd1;
        end
      end
      m_halted = m_idle ? 1'b0 : halt;
      m_idle   = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
